tick_input_buffer: RTL and testbench
====================================

# tick_input_buffer

Tick-framed input packet buffer sitting directly upstream of `RANCNetworkGrid_1x1`. The host writes packets and marks frame (image) boundaries; each grid `tick` releases exactly one committed frame. The grid drains the frame through `ren_to_input_buffer` / `input_buffer_empty` / `packet_in`. This replaces the memory-array feeder with synthesizable buffering and per-frame accounting.

## Interface
- `PACKET_WIDTH`, 30, packet width; must match the grid `packet_in`.
- `DEPTH`, 512, packet FIFO entries; must be a power of two.
- `FRAME_CNT_WIDTH`, 7, width of the per-frame packet count (maximum 127 packets per frame).
- `FRAME_QUEUE_DEPTH`, 8, number of committed-but-unreleased frame lengths held; power of two.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  host writes `wr_data` this cycle.
- `wr_data`  in  PACKET_WIDTH  packet from host.
- `frame_end`  in  1  closes the open frame; a coincident `wr_en` packet belongs to the closing frame.
- `full`  out  1  packet FIFO holds DEPTH entries.
- `frames_pending`  out  $clog2(FRAME_QUEUE_DEPTH+1)  number of committed frames not yet released.
- `tick`  in  1  grid tick; releases the next committed frame.
- `ren_to_input_buffer`  in  1  grid read request.
- `packet_in`  out  PACKET_WIDTH  registered packet to the grid.
- `input_buffer_empty`  out  1  released frame has no packets left.
- `overflow_error`  out  1  sticky; a write or frame commit was dropped.
- `underflow_error`  out  1  sticky; a read was attempted while empty.
- `frame_overrun`  out  1  sticky; a tick arrived before the previous frame was fully read.

## Operation
- **Write side.** `open_cnt` counts packets accepted into the open frame.
  - An accepted write stores the packet at `wr_ptr`, then increments `wr_ptr` and `open_cnt`.
  - A write is dropped and sets `overflow_error` if `full` is high, or if `open_cnt` equals 2^FRAME_CNT_WIDTH−1.
- **Frame commit.** On `frame_end`, push `open_cnt` into the length queue; include a coincident accepted write in the pushed count. Then clear `open_cnt`.
  - Zero-length frames are legal and are pushed.
  - If the length queue is full, the commit is dropped and `overflow_error` is set. The packets stay in the open frame and `open_cnt` is not cleared.
- **Release.** `remaining` holds the count of unread packets in the released frame.
  - On `tick`, pop the queue head into `remaining`.
  - If the queue is empty, load 0: an empty frame, with no error.
- **Read.** `ren_to_input_buffer` with `remaining != 0` and no `tick` does three things at that edge:
  - `packet_in <= mem[rd_ptr]`;
  - `rd_ptr` increments;
  - `remaining` decrements.
- **Ignored reads.**
  - A read with `remaining == 0` is ignored and sets `underflow_error`.
  - A read in a `tick` cycle is ignored with no error; `tick` has priority.
- **Overrun.** On `tick` with `remaining != 0`, set `frame_overrun`; the leftover is handled per Configuration.
- Pointers wrap modulo DEPTH. The FIFO count includes both released and unreleased packets. `full` = (count == DEPTH).
- A push and a pop on the length queue in the same cycle are both honoured.

## Timing
- **Reset values:**
  - `packet_in` = 0;
  - `input_buffer_empty` = 1;
  - `full` = 0;
  - `frames_pending` = 0;
  - all three error flags = 0;
  - all pointers and counters = 0.
- Reset mid-frame discards all stored packets and queued lengths.
- `input_buffer_empty` is `(remaining == 0)` decoded from the register, with no combinational path from inputs. It falls the cycle after the `tick` edge if the released length is nonzero.
- Read latency: `packet_in` is valid one cycle after the edge that sampled `ren_to_input_buffer`. It holds its value until the next accepted read.
- Earliest visibility of a write: `wr_en` and `frame_end` at edge N, `tick` at edge N+1, `ren` accepted at edge N+2, data valid after N+2.
- `frames_pending` and `full` update at the edge that causes the change.

## Configuration
- `TICK_INPUT_BUFFER_DISCARD_EN`:
  - **Defined:** on an overrun tick, `rd_ptr += remaining` in the same edge, discarding the leftovers. `remaining` is then loaded with the new head length.
  - **Undefined:** leftovers carry forward. `remaining <= remaining + head length`, saturating at 2^FRAME_CNT_WIDTH−1 and setting `overflow_error` on saturation.
  - `frame_overrun` is set in both builds.

## Test plan
- Reset, write 3 packets (0x1, 0x2, 0x3) with `frame_end` on the third, then tick → `frames_pending` goes 1→0, empty falls next cycle, and 3 reads return 0x1, 0x2, 0x3. Empty rises after the third read, with no errors.
- Tick with the queue empty → empty stays 1, and `ren` sets `underflow_error`.
- Commit frames of 2, 0, and 4 packets, then apply 3 ticks, reading fully each time → 2, 0, and 4 packets are delivered in order.
- Commit frames of 5 and 2 packets, read 2, then tick →
  - DISCARD build: the next reads return the second frame's 2 packets;
  - non-DISCARD build: 5 packets are returned (3 leftover + 2).
  - `frame_overrun` = 1 in both builds.
- Fill to DEPTH, then one more `wr_en` → `full` = 1, the write is dropped, and `overflow_error` = 1. After one frame is released and read, `full` = 0.
- Apply 9 commits with no tick at FRAME_QUEUE_DEPTH = 8 → `frames_pending` = 8, `overflow_error` = 1, and the ninth frame's packets are still counted in the open frame.

Source files
------------

// File: rtl/tick_input_buffer.sv
// Tick-framed packet buffer feeding the grid: the host writes packets and closes frames, and each grid tick releases one committed frame.
// Optional macro TICK_INPUT_BUFFER_DISCARD_EN: an overrun tick drops the unread leftovers instead of carrying them into the next frame.
module tick_input_buffer #(
    parameter int PACKET_WIDTH      = 30,
    parameter int DEPTH             = 512,
    parameter int FRAME_CNT_WIDTH   = 7,
    parameter int FRAME_QUEUE_DEPTH = 8
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   wr_en,
    input  logic [PACKET_WIDTH-1:0]                wr_data,
    input  logic                                   frame_end,
    output logic                                   full,
    output logic [$clog2(FRAME_QUEUE_DEPTH+1)-1:0] frames_pending,
    input  logic                                   tick,
    input  logic                                   ren_to_input_buffer,
    output logic [PACKET_WIDTH-1:0]                packet_in,
    output logic                                   input_buffer_empty,
    output logic                                   overflow_error,
    output logic                                   underflow_error,
    output logic                                   frame_overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int QW = $clog2(FRAME_QUEUE_DEPTH);
    localparam int PW = $clog2(FRAME_QUEUE_DEPTH + 1);
    localparam logic [FRAME_CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [PACKET_WIDTH-1:0]    mem [DEPTH];
    logic [FRAME_CNT_WIDTH-1:0] len_q [FRAME_QUEUE_DEPTH];

    logic [AW-1:0]              wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]              count_reg, count_next;
    logic [FRAME_CNT_WIDTH-1:0] open_cnt_reg, remaining_reg, remaining_next;
    logic [QW-1:0]              q_wr_ptr_reg, q_rd_ptr_reg;
    logic [PW-1:0]              pending_reg;
    logic [PACKET_WIDTH-1:0]    packet_in_reg;
    logic                       overflow_reg, underflow_reg, overrun_reg;

    logic                       wr_accept, wr_drop, q_full, q_empty;
    logic                       commit, commit_drop, pop;
    logic                       rd_accept, rd_under, overrun, sat_err;
    logic [FRAME_CNT_WIDTH-1:0] head_len, push_len, discard_cnt;

    assign full               = (count_reg == CW'(DEPTH));
    assign frames_pending     = pending_reg;
    assign packet_in          = packet_in_reg;
    assign input_buffer_empty = (remaining_reg == '0);
    assign overflow_error     = overflow_reg;
    assign underflow_error    = underflow_reg;
    assign frame_overrun      = overrun_reg;

    assign wr_accept   = wr_en && !full && (open_cnt_reg != CNT_MAX);
    assign wr_drop     = wr_en && !wr_accept;
    assign q_full      = (pending_reg == PW'(FRAME_QUEUE_DEPTH));
    assign q_empty     = (pending_reg == '0);
    assign commit      = frame_end && !q_full;
    assign commit_drop = frame_end && q_full;
    assign pop         = tick && !q_empty;
    // A tick with nothing queued releases an empty frame rather than erroring.
    assign head_len    = q_empty ? '0 : len_q[q_rd_ptr_reg];
    // open_cnt is below CNT_MAX whenever a write is accepted, so this cannot wrap.
    assign push_len    = open_cnt_reg + FRAME_CNT_WIDTH'(wr_accept);
    assign rd_accept   = ren_to_input_buffer && !tick && (remaining_reg != '0);
    assign rd_under    = ren_to_input_buffer && !tick && (remaining_reg == '0);
    assign overrun     = tick && (remaining_reg != '0);

`ifndef TICK_INPUT_BUFFER_DISCARD_EN
    logic [FRAME_CNT_WIDTH:0] carry_sum;
    assign carry_sum = {1'b0, remaining_reg} + {1'b0, head_len};
`endif

    always_comb begin
        remaining_next = remaining_reg;
        discard_cnt    = '0;
        sat_err        = 1'b0;
        if (tick) begin
`ifdef TICK_INPUT_BUFFER_DISCARD_EN
            discard_cnt    = remaining_reg;
            remaining_next = head_len;
`else
            if (carry_sum[FRAME_CNT_WIDTH]) begin
                remaining_next = CNT_MAX;
                sat_err        = 1'b1;
            end else begin
                remaining_next = carry_sum[FRAME_CNT_WIDTH-1:0];
            end
`endif
        end else if (rd_accept) begin
            remaining_next = remaining_reg - FRAME_CNT_WIDTH'(1);
        end
    end

    // Occupancy covers released and unreleased packets alike.
    assign count_next = count_reg + CW'(wr_accept) - CW'(rd_accept) - CW'(discard_cnt);

    // Storage arrays carry no reset so they map onto RAM; pointers guard them.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr_reg] <= wr_data;
        if (commit)
            len_q[q_wr_ptr_reg] <= push_len;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            open_cnt_reg  <= '0;
            remaining_reg <= '0;
            q_wr_ptr_reg  <= '0;
            q_rd_ptr_reg  <= '0;
            pending_reg   <= '0;
            packet_in_reg <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (wr_accept)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_accept)
                packet_in_reg <= mem[rd_ptr_reg];
            rd_ptr_reg    <= rd_ptr_reg + AW'(rd_accept) + AW'(discard_cnt);
            count_reg     <= count_next;
            remaining_reg <= remaining_next;

            // A dropped commit leaves its packets in the still-open frame.
            if (commit)
                open_cnt_reg <= '0;
            else if (wr_accept)
                open_cnt_reg <= open_cnt_reg + FRAME_CNT_WIDTH'(1);

            if (commit)
                q_wr_ptr_reg <= q_wr_ptr_reg + QW'(1);
            if (pop)
                q_rd_ptr_reg <= q_rd_ptr_reg + QW'(1);
            pending_reg <= pending_reg + PW'(commit) - PW'(pop);

            overflow_reg  <= overflow_reg | wr_drop | commit_drop | sat_err;
            underflow_reg <= underflow_reg | rd_under;
            overrun_reg   <= overrun_reg | overrun;
        end
    end
endmodule

// File: tb/tb_tick_input_buffer.sv
// Scoreboard bench for tick_input_buffer: reads push expected packets, a monitor checks packet_in the cycle after each read.
module tb_tick_input_buffer;
    localparam int PW = 30;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en, frame_end, tick, ren_to_input_buffer;
    logic [PW-1:0] wr_data;
    logic          full, input_buffer_empty;
    logic [3:0]    frames_pending;
    logic [PW-1:0] packet_in;
    logic          overflow_error, underflow_error, frame_overrun;

    int vectors = 0;
    int miscompares = 0;

    logic [PW-1:0] exp_q[$];
    logic          exp_rd;
    logic          mon_fire = 1'b0;

    always #5 clk = ~clk;

    tick_input_buffer dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .wr_en               (wr_en),
        .wr_data             (wr_data),
        .frame_end           (frame_end),
        .full                (full),
        .frames_pending      (frames_pending),
        .tick                (tick),
        .ren_to_input_buffer (ren_to_input_buffer),
        .packet_in           (packet_in),
        .input_buffer_empty  (input_buffer_empty),
        .overflow_error      (overflow_error),
        .underflow_error     (underflow_error),
        .frame_overrun       (frame_overrun)
    );

    // Monitor: packet_in is due at the negedge following a read edge.
    always @(posedge clk) mon_fire <= ren_to_input_buffer && exp_rd && !tick;

    always @(negedge clk) begin
        if (mon_fire) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_empty: packet_in=0x%0h with no expected packet queued", packet_in);
            end else begin
                logic [PW-1:0] e;
                e = exp_q.pop_front();
                if (packet_in !== e) begin
                    miscompares++;
                    $display("FAIL packet: got 0x%0h expected 0x%0h", packet_in, e);
                end else begin
                    $display("read packet 0x%0h ok", packet_in);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("check %s = 0x%0h ok", name, act);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 0; frame_end = 0; tick = 0; ren_to_input_buffer = 0; exp_rd = 0; wr_data = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        step(); step();
        reset_n = 1;
        step();
    endtask

    task automatic wr(input logic [PW-1:0] d, input logic fe);
        wr_en = 1; wr_data = d; frame_end = fe;
        step();
        wr_en = 0; frame_end = 0;
    endtask

    task automatic commit_only();
        frame_end = 1;
        step();
        frame_end = 0;
    endtask

    task automatic do_tick();
        tick = 1;
        step();
        tick = 0;
    endtask

    task automatic rd(input logic [PW-1:0] e);
        exp_q.push_back(e);
        ren_to_input_buffer = 1; exp_rd = 1;
        step();
        ren_to_input_buffer = 0; exp_rd = 0;
    endtask

    task automatic rd_bad();
        ren_to_input_buffer = 1;
        step();
        ren_to_input_buffer = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0;
        idle();
        step();
        do_reset();

        // Reset state
        check("rst_packet_in", 32'(packet_in), 32'h0);
        check("rst_empty", 32'(input_buffer_empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_pending", 32'(frames_pending), 32'h0);
        check("rst_errors", {29'h0, overflow_error, underflow_error, frame_overrun}, 32'h0);

        // Basic frame of three
        wr(30'h1, 0); wr(30'h2, 0); wr(30'h3, 1);
        check("t1_pending_before", 32'(frames_pending), 32'h1);
        do_tick();
        check("t1_pending_after", 32'(frames_pending), 32'h0);
        check("t1_empty_fall", 32'(input_buffer_empty), 32'h0);
        rd(30'h1); rd(30'h2);
        check("t1_empty_mid", 32'(input_buffer_empty), 32'h0);
        rd(30'h3);
        check("t1_empty_rise", 32'(input_buffer_empty), 32'h1);
        check("t1_errors", {29'h0, overflow_error, underflow_error, frame_overrun}, 32'h0);

        // Tick with nothing queued, then an underflowing read
        do_tick();
        check("t2_empty", 32'(input_buffer_empty), 32'h1);
        check("t2_no_underflow", 32'(underflow_error), 32'h0);
        rd_bad();
        check("t2_underflow", 32'(underflow_error), 32'h1);
        check("t2_packet_hold", 32'(packet_in), 32'h3);

        // Frames of 2, 0, 4
        do_reset();
        wr(30'h10, 0); wr(30'h11, 1);
        commit_only();
        wr(30'h20, 0); wr(30'h21, 0); wr(30'h22, 0); wr(30'h23, 1);
        check("t3_pending", 32'(frames_pending), 32'h3);
        do_tick();
        rd(30'h10); rd(30'h11);
        check("t3_empty_f0", 32'(input_buffer_empty), 32'h1);
        do_tick();
        check("t3_empty_zero_frame", 32'(input_buffer_empty), 32'h1);
        do_tick();
        check("t3_empty_f2", 32'(input_buffer_empty), 32'h0);
        rd(30'h20); rd(30'h21); rd(30'h22); rd(30'h23);
        check("t3_errors", {29'h0, overflow_error, underflow_error, frame_overrun}, 32'h0);

        // Overrun: frame of 5 partly read, then tick onto frame of 2
        do_reset();
        for (int i = 0; i < 5; i++) wr(30'h30 + 30'(i), i == 4);
        wr(30'h40, 0); wr(30'h41, 1);
        do_tick();
        rd(30'h30); rd(30'h31);
        do_tick();
        check("t4_overrun", 32'(frame_overrun), 32'h1);
`ifndef TICK_INPUT_BUFFER_DISCARD_EN
        rd(30'h32); rd(30'h33); rd(30'h34);
`endif
        rd(30'h40); rd(30'h41);
        check("t4_empty_end", 32'(input_buffer_empty), 32'h1);
        check("t4_no_overflow", 32'(overflow_error), 32'h0);

        // Fill to DEPTH in frames of 127, then one extra write
        do_reset();
        for (int i = 0; i < 512; i++) wr(30'(i), (i % 127) == 126);
        check("t5_full", 32'(full), 32'h1);
        check("t5_no_overflow", 32'(overflow_error), 32'h0);
        check("t5_pending", 32'(frames_pending), 32'h4);
        wr(30'h3ff, 0);
        check("t5_overflow", 32'(overflow_error), 32'h1);
        check("t5_full_hold", 32'(full), 32'h1);
        do_tick();
        for (int i = 0; i < 127; i++) rd(30'(i));
        check("t5_not_full", 32'(full), 32'h0);

        // Nine commits against an eight-deep length queue
        do_reset();
        for (int k = 0; k < 8; k++) wr(30'h50 + 30'(k), 1);
        check("t6_pending8", 32'(frames_pending), 32'h8);
        check("t6_no_overflow", 32'(overflow_error), 32'h0);
        wr(30'h58, 1);
        check("t6_pending_cap", 32'(frames_pending), 32'h8);
        check("t6_overflow", 32'(overflow_error), 32'h1);
        do_tick();
        check("t6_pending_pop", 32'(frames_pending), 32'h7);
        rd(30'h50);
        commit_only();
        check("t6_pending_recommit", 32'(frames_pending), 32'h8);
        for (int k = 1; k < 9; k++) begin
            do_tick();
            check("t6_empty_frame", 32'(input_buffer_empty), 32'h0);
            rd(30'h50 + 30'(k));
        end
        check("t6_pending_end", 32'(frames_pending), 32'h0);
        check("t6_empty_end", 32'(input_buffer_empty), 32'h1);

        step();
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
